// File: rtl/aste_slot_scheduler.sv
// ---------------------------------------------------------------------------
// aste_slot_scheduler
//
// Purpose:
//   Owns the 16-entry x 2-bit asteroid status memory and arbitrates it between
//   four clients: game-reset clear, asteroid kill, asteroid spawn (lowest free
//   slot search) and the per-frame scan used by render/collision. Also keeps a
//   live count of occupied slots (any slot state other than 00).
//
//   Slot encoding: 00 free, 01 active, 10 exploding, 11 reserved.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   clear_req / clear_ack        wipe every slot
//   kill_req / kill_slot /
//   kill_ack / kill_hit          free one slot, report whether it was occupied
//   spawn_req / spawn_ack /
//   spawn_fail / spawn_slot      allocate the lowest free slot as active
//   scan_start / scan_valid /
//   scan_slot / scan_state /
//   scan_done                    stream all 16 slots in ascending order
//   mem_we, mem_clear, mem_addr,
//   mem_data, mem_q              status memory port (registered read address)
//   active_count                 occupied slots, 0..16
//   busy                         scheduler is not idle
//   dbg_state                    current FSM state, for checkers
//
// Handshake: every *_req / scan_start is a level held by its client until the
//   matching one-cycle ack/fail/done pulse. Requests are only sampled while
//   the scheduler is idle, so a request still held after its pulse is seen as
//   a fresh request on the next idle cycle. A granted operation always runs to
//   completion unless reset aborts it (no pulse is issued in that case).
// ---------------------------------------------------------------------------
module aste_slot_scheduler #(
    parameter int N_SLOTS = 16,
    parameter int AW      = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_req,
    output logic          clear_ack,
    input  logic          kill_req,
    input  logic [AW-1:0] kill_slot,
    output logic          kill_ack,
    output logic          kill_hit,
    input  logic          spawn_req,
    output logic          spawn_ack,
    output logic          spawn_fail,
    output logic [AW-1:0] spawn_slot,
    input  logic          scan_start,
    output logic          scan_valid,
    output logic [AW-1:0] scan_slot,
    output logic [1:0]    scan_state,
    output logic          scan_done,
    output logic          mem_we,
    output logic          mem_clear,
    output logic [AW-1:0] mem_addr,
    output logic [1:0]    mem_data,
    input  logic [1:0]    mem_q,
    output logic [4:0]    active_count,
    output logic          busy,
    output logic [3:0]    dbg_state
);

    localparam logic [1:0] SLOT_FREE   = 2'b00;
    localparam logic [1:0] SLOT_ACTIVE = 2'b01;
    localparam logic [4:0] LAST_IDX    = 5'(N_SLOTS);

    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_IDLE     = 4'd1,
        S_CLEAR    = 4'd2,
        S_KILL_RD  = 4'd3,
        S_KILL_WR  = 4'd4,
        S_SEARCH   = 4'd5,
        S_SPAWN_WR = 4'd6,
        S_SCAN     = 4'd7
    } state_e;

    state_e        state_q,      state_d;
    logic [4:0]    idx_q,        idx_d;        // pipeline index, 0..N_SLOTS
    logic [AW-1:0] slot_q,       slot_d;       // latched kill / found spawn slot
    logic [AW-1:0] spawn_slot_q, spawn_slot_d;
    logic [4:0]    count_q,      count_d;

    // Slot whose read data is arriving on mem_q this cycle.
    logic [4:0]    idx_m1;
    assign idx_m1 = idx_q - 5'd1;

    assign spawn_slot   = spawn_slot_q;
    assign active_count = count_q;
    assign dbg_state    = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_INIT;
            idx_q        <= '0;
            slot_q       <= '0;
            spawn_slot_q <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            slot_q       <= slot_d;
            spawn_slot_q <= spawn_slot_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        slot_d       = slot_q;
        spawn_slot_d = spawn_slot_q;
        count_d      = count_q;

        clear_ack    = 1'b0;
        kill_ack     = 1'b0;
        kill_hit     = 1'b0;
        spawn_ack    = 1'b0;
        spawn_fail   = 1'b0;
        scan_valid   = 1'b0;
        scan_slot    = '0;
        scan_state   = SLOT_FREE;
        scan_done    = 1'b0;
        mem_we       = 1'b0;
        mem_clear    = 1'b0;
        mem_addr     = '0;
        mem_data     = SLOT_FREE;
        busy         = (state_q != S_IDLE);

        case (state_q)
            S_INIT: begin
                // Memory survives reset; wiping it here keeps it in step with
                // the zeroed occupancy counter.
                mem_clear = 1'b1;
                count_d   = '0;
                state_d   = S_IDLE;
            end

            S_IDLE: begin
                idx_d = '0;
                if (clear_req) begin
                    state_d = S_CLEAR;
                end else if (kill_req) begin
                    slot_d  = kill_slot;
                    state_d = S_KILL_RD;
                end else if (spawn_req) begin
                    state_d = S_SEARCH;
                end else if (scan_start) begin
                    state_d = S_SCAN;
                end
            end

            S_CLEAR: begin
                mem_clear = 1'b1;
                clear_ack = 1'b1;
                count_d   = '0;
                state_d   = S_IDLE;
            end

            S_KILL_RD: begin
                mem_addr = slot_q;
                state_d  = S_KILL_WR;
            end

            S_KILL_WR: begin
                mem_addr = slot_q;
                kill_ack = 1'b1;
                kill_hit = (mem_q != SLOT_FREE);
                if (mem_q != SLOT_FREE) begin
                    mem_we   = 1'b1;
                    mem_data = SLOT_FREE;
                    if (count_q != 5'd0) begin
                        count_d = count_q - 5'd1;
                    end
                end
                state_d = S_IDLE;
            end

            S_SEARCH: begin
                // Address idx is issued while the data for idx-1 comes back,
                // so one slot is examined per cycle. At idx == N_SLOTS the
                // address is a don't-care read; only slot N_SLOTS-1 is judged.
                mem_addr = idx_q[AW-1:0];
                idx_d    = idx_q + 5'd1;
                if ((idx_q != 5'd0) && (mem_q == SLOT_FREE)) begin
                    slot_d  = idx_m1[AW-1:0];
                    state_d = S_SPAWN_WR;
                end else if (idx_q == LAST_IDX) begin
                    spawn_fail = 1'b1;
                    state_d    = S_IDLE;
                end
            end

            S_SPAWN_WR: begin
                mem_we       = 1'b1;
                mem_addr     = slot_q;
                mem_data     = SLOT_ACTIVE;
                spawn_ack    = 1'b1;
                spawn_slot_d = slot_q;
                if (count_q != LAST_IDX) begin
                    count_d = count_q + 5'd1;
                end
                state_d = S_IDLE;
            end

            S_SCAN: begin
                mem_addr = idx_q[AW-1:0];
                idx_d    = idx_q + 5'd1;
                if (idx_q != 5'd0) begin
                    scan_valid = 1'b1;
                    scan_slot  = idx_m1[AW-1:0];
                    scan_state = mem_q;
                end
                if (idx_q == LAST_IDX) begin
                    scan_done = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                state_d = S_INIT;
            end
        endcase

        // While reset is held every output is quiet, including mem_clear,
        // so reset itself never touches the memory.
        if (reset) begin
            clear_ack  = 1'b0;
            kill_ack   = 1'b0;
            kill_hit   = 1'b0;
            spawn_ack  = 1'b0;
            spawn_fail = 1'b0;
            scan_valid = 1'b0;
            scan_slot  = '0;
            scan_state = SLOT_FREE;
            scan_done  = 1'b0;
            mem_we     = 1'b0;
            mem_clear  = 1'b0;
            mem_addr   = '0;
            mem_data   = SLOT_FREE;
            busy       = 1'b0;
        end
    end

endmodule

// File: tb/tb_aste_slot_scheduler.sv
// ---------------------------------------------------------------------------
// tb_aste_slot_scheduler
//
// Directed bench for aste_slot_scheduler. A behavioural 16 x 2-bit status
// memory (synchronous write/clear, registered read address) is attached to
// the memory port. exp_mem holds the slot contents the bench expects, updated
// by hand as each operation completes.
// ---------------------------------------------------------------------------
module tb_aste_slot_scheduler;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       clear_req, clear_ack;
  logic       kill_req, kill_ack, kill_hit;
  logic [3:0] kill_slot;
  logic       spawn_req, spawn_ack, spawn_fail;
  logic [3:0] spawn_slot;
  logic       scan_start, scan_valid, scan_done;
  logic [3:0] scan_slot;
  logic [1:0] scan_state;
  logic       mem_we, mem_clear;
  logic [3:0] mem_addr;
  logic [1:0] mem_data, mem_q;
  logic [4:0] active_count;
  logic       busy;
  logic [3:0] dbg_state;

  aste_slot_scheduler #(.N_SLOTS(16), .AW(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear_req    (clear_req),
    .clear_ack    (clear_ack),
    .kill_req     (kill_req),
    .kill_slot    (kill_slot),
    .kill_ack     (kill_ack),
    .kill_hit     (kill_hit),
    .spawn_req    (spawn_req),
    .spawn_ack    (spawn_ack),
    .spawn_fail   (spawn_fail),
    .spawn_slot   (spawn_slot),
    .scan_start   (scan_start),
    .scan_valid   (scan_valid),
    .scan_slot    (scan_slot),
    .scan_state   (scan_state),
    .scan_done    (scan_done),
    .mem_we       (mem_we),
    .mem_clear    (mem_clear),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_q        (mem_q),
    .active_count (active_count),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // status memory model; preload fills it with occupied garbage before reset
  logic [1:0] ram [16];
  logic [3:0] ram_addr_q;
  logic       preload;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) ram[i] <= 2'($urandom_range(1, 3));
    end else if (mem_clear) begin
      for (int i = 0; i < 16; i++) ram[i] <= 2'b00;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_data;
    end
    ram_addr_q <= mem_addr;
  end
  assign mem_q = ram[ram_addr_q];

  // scoreboard
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_clash = 0;
  logic [1:0] exp_mem [16];
  logic [2:0] exp_q [$];

  always @(negedge clk) begin
    if (mem_we && mem_clear) n_clash++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 50);
    if (busy) check("idle_timeout", 32'(busy), 0);
  endtask

  task automatic spawn_expect(input int exp_ok, input int exp_slot, input int exp_lat,
                              input int exp_cnt);
    int         lat, nw;
    logic       got_ack, got_fail;
    logic [3:0] w_addr;
    logic [1:0] w_data;
    lat = 0; nw = 0; got_ack = 0; got_fail = 0; w_addr = '0; w_data = '0;
    wait_idle();
    spawn_req = 1'b1;
    while (!got_ack && !got_fail && lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_we) begin
        nw++;
        w_addr = mem_addr;
        w_data = mem_data;
      end
      got_ack  = spawn_ack;
      got_fail = spawn_fail;
    end
    spawn_req = 1'b0;
    check("spawn_ack", 32'(got_ack), exp_ok);
    check("spawn_fail", 32'(got_fail), 1 - exp_ok);
    check("spawn_lat", lat, exp_lat);
    check("spawn_wr_n", nw, exp_ok);
    if (exp_ok != 0) begin
      check("spawn_wr_addr", 32'(w_addr), exp_slot);
      check("spawn_wr_data", 32'(w_data), 1);
      exp_mem[exp_slot[3:0]] = 2'b01;
    end
    @(negedge clk);
    if (exp_ok != 0) check("spawn_slot", 32'(spawn_slot), exp_slot);
    check("spawn_cnt", 32'(active_count), exp_cnt);
  endtask

  task automatic kill_expect(input int s, input int exp_hit, input int exp_cnt);
    int         lat, nw;
    logic       got_ack, got_hit;
    logic [3:0] w_addr;
    logic [1:0] w_data;
    lat = 0; nw = 0; got_ack = 0; got_hit = 0; w_addr = '0; w_data = 2'b11;
    wait_idle();
    kill_slot = s[3:0];
    kill_req  = 1'b1;
    while (!got_ack && lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_we) begin
        nw++;
        w_addr = mem_addr;
        w_data = mem_data;
      end
      got_ack = kill_ack;
      got_hit = kill_hit;
    end
    kill_req = 1'b0;
    check("kill_ack", 32'(got_ack), 1);
    check("kill_lat", lat, 2);
    check("kill_hit", 32'(got_hit), exp_hit);
    check("kill_wr_n", nw, exp_hit);
    if (exp_hit != 0) begin
      check("kill_wr_addr", 32'(w_addr), s);
      check("kill_wr_data", 32'(w_data), 0);
    end
    exp_mem[s[3:0]] = 2'b00;
    @(negedge clk);
    check("kill_cnt", 32'(active_count), exp_cnt);
  endtask

  task automatic scan_expect();
    int   lat, nw, beats;
    logic done;
    lat = 0; nw = 0; beats = 0; done = 0;
    wait_idle();
    scan_start = 1'b1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_we) nw++;
      if (scan_valid) begin
        check("scan_slot", 32'(scan_slot), beats % 16);
        check("scan_state", 32'(scan_state), 32'(exp_mem[beats % 16]));
        beats++;
      end
      if (scan_done) begin
        done = 1'b1;
        check("scan_done_beat", beats, 16);
      end
    end
    scan_start = 1'b0;
    check("scan_done_seen", 32'(done), 1);
    check("scan_lat", lat, 17);
    check("scan_wr_n", nw, 0);
  endtask

  // directed sequence
  initial begin
    int         cyc, c_clr, c_kill, c_spawn, c_done, nack;
    logic       k_hit;
    logic [3:0] s_addr;
    logic [2:0] ev;

    reset = 1'b1; preload = 1'b1;
    clear_req = 0; kill_req = 0; kill_slot = '0; spawn_req = 0; scan_start = 0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 2'b00;

    // reset and INIT
    repeat (3) @(negedge clk);
    check("rst_outs", 32'({mem_clear, mem_we, busy, clear_ack, kill_ack, spawn_ack,
                           spawn_fail, scan_valid, scan_done}), 0);
    check("rst_cnt", 32'(active_count), 0);
    check("rst_spawn_slot", 32'(spawn_slot), 0);
    check("rst_state", 32'(dbg_state), 0);
    preload = 1'b0;
    reset   = 1'b0;
    #1;
    check("init_clear", 32'(mem_clear), 1);
    check("init_busy", 32'(busy), 1);
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_cnt", 32'(active_count), 0);
    scan_expect();

    // three spawns back-to-back, then a scan showing slots 0-2 active
    spawn_expect(1, 0, 3, 1);
    spawn_expect(1, 1, 4, 2);
    spawn_expect(1, 2, 5, 3);
    scan_expect();

    // fill every slot, then one more spawn must fail
    for (int s = 3; s < 16; s++) spawn_expect(1, s, s + 3, s + 1);
    spawn_expect(0, 0, 17, 16);

    // kill slot 1 twice, then respawn lands in slot 1
    kill_expect(1, 1, 15);
    kill_expect(1, 0, 15);
    spawn_expect(1, 1, 4, 16);
    scan_expect();

    // all four requests at once: clear > kill > spawn > scan
    for (int i = 0; i < 16; i++) exp_mem[i] = 2'b00;
    exp_mem[0] = 2'b01;
    exp_q = {3'd1, 3'd2, 3'd3, 3'd4};
    c_clr = -1; c_kill = -1; c_spawn = -1; c_done = -1; k_hit = 1'b1; s_addr = 4'hf;
    wait_idle();
    kill_slot = 4'd0;
    clear_req = 1; kill_req = 1; spawn_req = 1; scan_start = 1;
    cyc = 0;
    while (c_done < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      ev = 3'd0;
      if (clear_ack) begin c_clr = cyc; clear_req = 0; ev = 3'd1; end
      if (kill_ack) begin c_kill = cyc; k_hit = kill_hit; kill_req = 0; ev = 3'd2; end
      if (spawn_ack) begin c_spawn = cyc; s_addr = mem_addr; spawn_req = 0; ev = 3'd3; end
      if (scan_done) begin c_done = cyc; scan_start = 0; ev = 3'd4; end
      if (ev != 3'd0) begin
        if (exp_q.size() == 0) check("prio_extra_event", 32'(ev), 0);
        else check("prio_order", 32'(ev), 32'(exp_q.pop_front()));
      end
    end
    clear_req = 0; kill_req = 0; spawn_req = 0; scan_start = 0;
    check("prio_left", exp_q.size(), 0);
    check("prio_clr_cyc", c_clr, 1);
    check("prio_kill_cyc", c_kill, 4);
    check("prio_kill_hit", 32'(k_hit), 0);
    check("prio_spawn_cyc", c_spawn, 8);
    check("prio_spawn_slot", 32'(s_addr), 0);
    check("prio_done_cyc", c_done, 26);
    @(negedge clk);
    check("prio_cnt", 32'(active_count), 1);
    check("prio_spawn_reg", 32'(spawn_slot), 0);

    // reset in the middle of a search
    wait_idle();
    spawn_req = 1'b1;
    nack = 0;
    repeat (2) begin
      @(negedge clk);
      if (spawn_ack || spawn_fail) nack++;
    end
    reset = 1'b1;
    spawn_req = 1'b0;
    #1;
    check("midrst_cnt", 32'(active_count), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_state", 32'(dbg_state), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_init_clear", 32'(mem_clear), 1);
    repeat (20) begin
      @(negedge clk);
      if (spawn_ack || spawn_fail) nack++;
    end
    check("midrst_no_ack", nack, 0);
    check("midrst_cnt_after", 32'(active_count), 0);
    for (int i = 0; i < 16; i++) exp_mem[i] = 2'b00;
    scan_expect();

    check("we_clear_clash", n_clash, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
